// File: rtl/eight_bit_accumulator_if.sv
// Operand / result handshake bundle for eight_bit_accumulator.
// slave  : the accumulator (accepts operands, presents results)
// master : the producer/consumer driving operands and taking results
interface eight_bit_accumulator_if #(
    parameter int CW = 8
);
    logic          x_valid;
    logic          x_ready;
    logic [7:0]    x;
    logic          x_last;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s;
    logic          c_out;
    logic [CW-1:0] s_cnt;

    modport slave (
        input  x_valid,
        output x_ready,
        input  x,
        input  x_last,
        output s_valid,
        input  s_ready,
        output s,
        output c_out,
        output s_cnt
    );

    modport master (
        output x_valid,
        input  x_ready,
        output x,
        output x_last,
        input  s_valid,
        output s_ready,
        input  s,
        input  c_out,
        input  s_cnt
    );
endinterface

// File: rtl/eight_bit_accumulator.sv
// Group accumulator: adds a stream of 8-bit operands into a running sum
// through an 8-bit ripple-carry adder (x = operand, y = accumulator) and
// presents sum, sticky carry and operand count once per group.
// A group ends after N_OPS operands or on an operand flagged x_last.
// Optional build macro ACC_SATURATE_EN: clamp the accumulator to 8'hFF
// whenever the adder carries out, instead of wrapping modulo 256.
module eight_bit_accumulator #(
    parameter int N_OPS = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    eight_bit_accumulator_if.slave   bus
);
    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    acc;
    logic [CW-1:0] cnt;
    logic          carry;

    logic          s_valid_r;
    logic [7:0]    s_r;
    logic          c_out_r;
    logic [CW-1:0] s_cnt_r;

    logic [8:0]    rc;
    logic [7:0]    sum;
    logic          c7;
    logic [7:0]    acc_next;
    logic          carry_next;
    logic [CW-1:0] cnt_next;
    logic          x_ready_w;
    logic          accept;
    logic          group_end;

    // Ripple-carry add: bit i carry feeds bit i+1, c7 is the final carry-out
    always_comb begin
        rc    = '0;
        sum   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i]  = bus.x[i] ^ acc[i] ^ rc[i];
            rc[i+1] = (bus.x[i] & acc[i]) | (rc[i] & (bus.x[i] ^ acc[i]));
        end
        c7 = rc[8];
    end

    // Next accumulator value, sticky carry and operand count for an accept
    always_comb begin
`ifdef ACC_SATURATE_EN
        acc_next = c7 ? 8'hFF : sum;
`else
        acc_next = sum;
`endif
        carry_next = carry | c7;
        cnt_next   = cnt + CW'(1);
    end

    // Handshake decode: operands only taken while accumulating
    always_comb begin
        x_ready_w = (state == ACC);
        accept    = bus.x_valid && x_ready_w;
        group_end = accept && ((cnt == CW'(N_OPS - 1)) || bus.x_last);
    end

    // Group FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            s_valid_r <= 1'b0;
            s_r       <= '0;
            c_out_r   <= 1'b0;
            s_cnt_r   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc   <= acc_next;
                        carry <= carry_next;
                        cnt   <= cnt_next;
                        if (group_end) begin
                            s_r       <= acc_next;
                            c_out_r   <= carry_next;
                            s_cnt_r   <= cnt_next;
                            s_valid_r <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results persist after release; only the working state clears
                    if (bus.s_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        carry     <= 1'b0;
                        s_valid_r <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

    assign bus.x_ready = x_ready_w;
    assign bus.s_valid = s_valid_r;
    assign bus.s       = s_r;
    assign bus.c_out   = c_out_r;
    assign bus.s_cnt   = s_cnt_r;
endmodule

// File: tb/tb_eight_bit_accumulator.sv
// Self-checking bench for eight_bit_accumulator: two instances (N_OPS=4 and
// N_OPS=1) driven with identical directed and random stimulus, compared each
// cycle against an integer-sum group model.
module tb_eight_bit_accumulator;
    logic       clk;
    logic       rst;
    logic       xv;
    logic [7:0] xd;
    logic       xl;
    logic       sr;

    int n_checks;
    int n_pass;

    // Reference model state per instance: index 0 -> N_OPS=4, 1 -> N_OPS=1
    int nops [2];
    bit pend [2];
    int tot  [2];
    int n    [2];
    int es   [2];
    int ec   [2];
    int ecnt [2];

    eight_bit_accumulator_if #(.CW(8)) ifc4 ();
    eight_bit_accumulator_if #(.CW(8)) ifc1 ();

    assign ifc4.x_valid = xv;
    assign ifc4.x       = xd;
    assign ifc4.x_last  = xl;
    assign ifc4.s_ready = sr;
    assign ifc1.x_valid = xv;
    assign ifc1.x       = xd;
    assign ifc1.x_last  = xl;
    assign ifc1.s_ready = sr;

    eight_bit_accumulator #(.N_OPS(4), .CW(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifc4)
    );

    eight_bit_accumulator #(.N_OPS(1), .CW(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Group-level behaviour: sum operands as plain integers, close the group
    // on count or last flag, derive the presented sum from the total.
    task automatic model_edge(input int i, input bit r, input bit v, input int d,
                              input bit l, input bit rdy);
        if (r) begin
            pend[i] = 1'b0;
            tot[i]  = 0;
            n[i]    = 0;
            es[i]   = 0;
            ec[i]   = 0;
            ecnt[i] = 0;
        end else if (pend[i]) begin
            if (rdy) begin
                pend[i] = 1'b0;
                tot[i]  = 0;
                n[i]    = 0;
            end
        end else if (v) begin
            tot[i] = tot[i] + d;
            n[i]   = n[i] + 1;
            if (n[i] == nops[i] || l) begin
`ifdef ACC_SATURATE_EN
                es[i] = (tot[i] > 255) ? 255 : tot[i];
`else
                es[i] = tot[i] % 256;
`endif
                ec[i]   = (tot[i] > 255) ? 1 : 0;
                ecnt[i] = n[i];
                pend[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string name, input int i, input logic xr,
                                 input logic sv, input logic [7:0] s,
                                 input logic c, input logic [7:0] cnt);
        check({name, "_x_ready"}, 32'(xr), 32'(!pend[i]));
        check({name, "_s_valid"}, 32'(sv), 32'(pend[i]));
        check({name, "_s"},       32'(s),  32'(es[i]));
        check({name, "_c_out"},   32'(c),  32'(ec[i]));
        check({name, "_s_cnt"},   32'(cnt), 32'(ecnt[i]));
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, then check
    task automatic step(input bit r, input bit v, input int d, input bit l, input bit rdy);
        rst = r;
        xv  = v;
        xd  = d[7:0];
        xl  = l;
        sr  = rdy;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, r, v, d & 255, l, rdy);
        #1;
        check_outputs("n4", 0, ifc4.x_ready, ifc4.s_valid, ifc4.s, ifc4.c_out, ifc4.s_cnt);
        check_outputs("n1", 1, ifc1.x_ready, ifc1.s_valid, ifc1.s, ifc1.c_out, ifc1.s_cnt);
    endtask

    task automatic feed(input int d, input bit l);
        step(1'b0, 1'b1, d, l, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        xv       = 1'b0;
        xd       = '0;
        xl       = 1'b0;
        sr       = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        nops[0]  = 4;
        nops[1]  = 1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0;
            tot[i]  = 0;
            n[i]    = 0;
            es[i]   = 0;
            ec[i]   = 0;
            ecnt[i] = 0;
        end

        // Basic group after a two-cycle reset
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("reset_x_ready", 32'(ifc4.x_ready), 32'd1);
        check("reset_s_valid", 32'(ifc4.s_valid), 32'd0);
        feed(1, 1'b0);
        feed(2, 1'b0);
        feed(3, 1'b0);
        feed(4, 1'b0);
        check("basic_s", 32'(ifc4.s), 32'd10);
        check("basic_cnt", 32'(ifc4.s_cnt), 32'd4);
        check("basic_x_ready", 32'(ifc4.x_ready), 32'd0);
        idle();
        check("basic_s_valid_fall", 32'(ifc4.s_valid), 32'd0);

        // Overflow
        feed(200, 1'b0);
        feed(100, 1'b0);
        feed(0, 1'b0);
        feed(0, 1'b0);
`ifdef ACC_SATURATE_EN
        check("ovf_s", 32'(ifc4.s), 32'd255);
`else
        check("ovf_s", 32'(ifc4.s), 32'd44);
`endif
        check("ovf_c", 32'(ifc4.c_out), 32'd1);
        idle();

        // Early termination, then a clean group
        feed(5, 1'b0);
        feed(7, 1'b1);
        check("early_s", 32'(ifc4.s), 32'd12);
        check("early_cnt", 32'(ifc4.s_cnt), 32'd2);
        check("early_c", 32'(ifc4.c_out), 32'd0);
        idle();
        for (int k = 0; k < 4; k++) feed(1, 1'b0);
        check("after_early_s", 32'(ifc4.s), 32'd4);
        idle();

        // Backpressure with operands pending throughout
        feed(10, 1'b0);
        feed(20, 1'b0);
        feed(30, 1'b0);
        feed(40, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 99, 1'b0, 1'b0);
            check("bp_s", 32'(ifc4.s), 32'd100);
            check("bp_hold_valid", 32'(ifc4.s_valid), 32'd1);
        end
        step(1'b0, 1'b1, 99, 1'b0, 1'b1);
        step(1'b0, 1'b1, 99, 1'b0, 1'b1);
        feed(1, 1'b0);
        feed(1, 1'b0);
        feed(1, 1'b0);
        check("bp_next_s", 32'(ifc4.s), 32'd102);
        idle();

        // Reset in the middle of a group
        feed(9, 1'b0);
        feed(9, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) feed(1, 1'b0);
        check("midrst_s", 32'(ifc4.s), 32'd4);
        check("midrst_cnt", 32'(ifc4.s_cnt), 32'd4);
        check("midrst_c", 32'(ifc4.c_out), 32'd0);
        idle();

        // Gapped input
        for (int v = 1; v <= 4; v++) begin
            feed(v, 1'b0);
            if (v < 4) begin
                idle();
                idle();
            end
        end
        check("gap_s", 32'(ifc4.s), 32'd10);
        check("gap_cnt", 32'(ifc4.s_cnt), 32'd4);
        idle();
        feed(255, 1'b0);
        check("single_s", 32'(ifc1.s), 32'd255);
        check("single_c", 32'(ifc1.c_out), 32'd0);
        check("single_cnt", 32'(ifc1.s_cnt), 32'd1);
        idle();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
